// File: rtl/in128_out1536.sv
// in128_out1536: AXI-Stream upsizer, packs 128-bit beats into 1536-bit words.
// Lane 0 sits in the LSBs; per-lane tlast is carried in a RATIO-bit vector.
module in128_out1536 #(
  parameter int unsigned IN_WIDTH = 128,
  parameter int unsigned RATIO    = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [IN_WIDTH-1:0]          s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic                         s_axis_tlast,
  output logic [IN_WIDTH*RATIO-1:0]    m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [RATIO-1:0]             m_axis_tlast,
  output logic [15:0]                  word_count
);

  localparam int unsigned OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int unsigned LANE_W    = $clog2(RATIO);
  localparam int unsigned CNT_W     = 16;

  logic [LANE_W-1:0]    lane_cnt_q,  lane_cnt_d;
  logic [OUT_WIDTH-1:0] acc_q,       acc_d;
  logic [RATIO-1:0]     acc_tlast_q, acc_tlast_d;
  logic                 pending_q,   pending_d;
  logic                 s_tready_q,  s_tready_d;
  logic [OUT_WIDTH-1:0] m_tdata_q,   m_tdata_d;
  logic [RATIO-1:0]     m_tlast_q,   m_tlast_d;
  logic                 m_tvalid_q,  m_tvalid_d;
  logic [CNT_W-1:0]     wcnt_q,      wcnt_d;

  logic [OUT_WIDTH-1:0] merged_data;
  logic [RATIO-1:0]     merged_tlast;
  logic                 in_hs, out_hs, slot_free, completing;

  assign in_hs      = s_axis_tvalid & s_tready_q;
  assign out_hs     = m_tvalid_q & m_axis_tready;
  assign slot_free  = ~m_tvalid_q | m_axis_tready;
  assign completing = in_hs & ((lane_cnt_q == LANE_W'(RATIO - 1)) | s_axis_tlast);

  // Accumulator with the current beat dropped into lane lane_cnt.
  always_comb begin
    merged_data  = acc_q;
    merged_tlast = acc_tlast_q;
    for (int k = 0; k < int'(RATIO); k++) begin
      if (lane_cnt_q == LANE_W'(k)) begin
        merged_data[k*IN_WIDTH +: IN_WIDTH] = s_axis_tdata;
        merged_tlast[k]                     = s_axis_tlast;
      end
    end
  end

  // Next-state: fill, emit, or park a finished word until the output slot frees.
  always_comb begin
    lane_cnt_d  = lane_cnt_q;
    acc_d       = acc_q;
    acc_tlast_d = acc_tlast_q;
    pending_d   = pending_q;
    m_tdata_d   = m_tdata_q;
    m_tlast_d   = m_tlast_q;
    m_tvalid_d  = m_tvalid_q & ~m_axis_tready;
    wcnt_d      = out_hs ? wcnt_q + CNT_W'(1) : wcnt_q;

    if (pending_q) begin
      if (slot_free) begin
        m_tdata_d   = acc_q;
        m_tlast_d   = acc_tlast_q;
        m_tvalid_d  = 1'b1;
        acc_d       = '0;
        acc_tlast_d = '0;
        lane_cnt_d  = '0;
        pending_d   = 1'b0;
      end
    end else if (in_hs) begin
      if (completing) begin
        lane_cnt_d = '0;
        if (slot_free) begin
          m_tdata_d   = merged_data;
          m_tlast_d   = merged_tlast;
          m_tvalid_d  = 1'b1;
          acc_d       = '0;
          acc_tlast_d = '0;
        end else begin
          acc_d       = merged_data;
          acc_tlast_d = merged_tlast;
          pending_d   = 1'b1;
        end
      end else begin
        acc_d       = merged_data;
        acc_tlast_d = merged_tlast;
        lane_cnt_d  = lane_cnt_q + LANE_W'(1);
      end
    end

    s_tready_d = ~pending_d;
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_cnt_q  <= '0;
      acc_q       <= '0;
      acc_tlast_q <= '0;
      pending_q   <= 1'b0;
      s_tready_q  <= 1'b1;
      m_tdata_q   <= '0;
      m_tlast_q   <= '0;
      m_tvalid_q  <= 1'b0;
      wcnt_q      <= '0;
    end else begin
      lane_cnt_q  <= lane_cnt_d;
      acc_q       <= acc_d;
      acc_tlast_q <= acc_tlast_d;
      pending_q   <= pending_d;
      s_tready_q  <= s_tready_d;
      m_tdata_q   <= m_tdata_d;
      m_tlast_q   <= m_tlast_d;
      m_tvalid_q  <= m_tvalid_d;
      wcnt_q      <= wcnt_d;
    end
  end

  assign s_axis_tready = s_tready_q;
  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tlast  = m_tlast_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign word_count    = wcnt_q;

endmodule

// File: tb/tb_in128_out1536.sv
// Directed bench for in128_out1536: vector table plus multi-cycle corner sequences.
module tb_in128_out1536;

  logic          clk = 1'b0;
  logic          rst;
  logic [127:0]  s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [1535:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [11:0]   m_axis_tlast;
  logic [15:0]   word_count;

  int total = 0;
  int bad   = 0;

  in128_out1536 dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .word_count    (word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [7:0] byt;
    logic       last;
    logic       mrdy;
    logic       e_srdy;
    logic       e_mvld;
    logic       chk_d;
    logic [11:0] e_tlast;
    logic [7:0] e_base;
    int         e_n;
    logic [15:0] e_wc;
  } vec_t;

  vec_t tbl[19];

  // Expected word: lanes 0..n-1 hold {16{base+k}}, upper lanes zero.
  function automatic logic [1535:0] exp_word(input logic [7:0] base, input int n);
    logic [1535:0] w;
    logic [7:0]    b;
    w = '0;
    for (int k = 0; k < 12; k++) begin
      b = base + 8'(k);
      if (k < n) w[k*128 +: 128] = {16{b}};
    end
    return w;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic chk_data(input string nm, input logic [1535:0] exp);
    total++;
    if (m_axis_tdata !== exp) begin
      bad++;
      for (int k = 0; k < 12; k++) begin
        if (m_axis_tdata[k*128 +: 128] !== exp[k*128 +: 128]) begin
          $display("FAIL %s lane %0d got=%h exp=%h", nm, k,
                   m_axis_tdata[k*128 +: 128], exp[k*128 +: 128]);
          break;
        end
      end
    end
  endtask

  task automatic apply(input logic vld, input logic [7:0] byt, input logic last, input logic mrdy);
    s_axis_tvalid = vld;
    s_axis_tdata  = {16{byt}};
    s_axis_tlast  = last;
    m_axis_tready = mrdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, "_srdy"}, 32'(s_axis_tready), 32'd1);
    chk({nm, "_mvld"}, 32'(m_axis_tvalid), 32'd0);
    chk({nm, "_tlast"}, 32'(m_axis_tlast), 32'd0);
    chk({nm, "_wc"}, 32'(word_count), 32'd0);
    chk_data({nm, "_data"}, '0);
  endtask

  initial begin
    rst = 1'b1;
    apply(1'b0, 8'h00, 1'b0, 1'b0);

    // Table: full word (rows 0-12), early tlast (rows 13-18).
    for (int k = 0; k < 12; k++) begin
      tbl[k] = '{vld: 1'b1, byt: 8'(k), last: (k == 11), mrdy: 1'b1,
                 e_srdy: 1'b1, e_mvld: (k == 11), chk_d: (k == 11),
                 e_tlast: 12'h800, e_base: 8'h00, e_n: 12, e_wc: 16'd0};
    end
    tbl[12] = '{vld: 1'b0, byt: 8'h00, last: 1'b0, mrdy: 1'b1,
                e_srdy: 1'b1, e_mvld: 1'b0, chk_d: 1'b0,
                e_tlast: 12'h000, e_base: 8'h00, e_n: 0, e_wc: 16'd1};
    for (int k = 0; k < 5; k++) begin
      tbl[13+k] = '{vld: 1'b1, byt: 8'hA0 + 8'(k), last: (k == 4), mrdy: 1'b1,
                    e_srdy: 1'b1, e_mvld: (k == 4), chk_d: (k == 4),
                    e_tlast: 12'h010, e_base: 8'hA0, e_n: 5, e_wc: 16'd1};
    end
    tbl[18] = '{vld: 1'b0, byt: 8'h00, last: 1'b0, mrdy: 1'b1,
                e_srdy: 1'b1, e_mvld: 1'b0, chk_d: 1'b0,
                e_tlast: 12'h000, e_base: 8'h00, e_n: 0, e_wc: 16'd2};

    #1;
    chk_reset_state("reset");
    step();
    step();
    @(negedge clk);
    rst = 1'b0;
    step();

    for (int i = 0; i < 19; i++) begin
      apply(tbl[i].vld, tbl[i].byt, tbl[i].last, tbl[i].mrdy);
      step();
      chk($sformatf("tbl%0d_srdy", i), 32'(s_axis_tready), 32'(tbl[i].e_srdy));
      chk($sformatf("tbl%0d_mvld", i), 32'(m_axis_tvalid), 32'(tbl[i].e_mvld));
      chk($sformatf("tbl%0d_wc", i), 32'(word_count), 32'(tbl[i].e_wc));
      if (tbl[i].chk_d) begin
        chk($sformatf("tbl%0d_tlast", i), 32'(m_axis_tlast), 32'(tbl[i].e_tlast));
        chk_data($sformatf("tbl%0d_data", i), exp_word(tbl[i].e_base, tbl[i].e_n));
      end
    end

    // Back-to-back: 36 beats, words after beats 11, 23, 35.
    for (int j = 0; j < 36; j++) begin
      apply(1'b1, 8'(j), (j == 35), 1'b1);
      step();
      chk($sformatf("b2b%0d_srdy", j), 32'(s_axis_tready), 32'd1);
      chk($sformatf("b2b%0d_mvld", j), 32'(m_axis_tvalid), 32'((j % 12) == 11));
      if ((j % 12) == 11) begin
        chk($sformatf("b2b%0d_tlast", j), 32'(m_axis_tlast), (j == 35) ? 32'h800 : 32'h000);
        chk_data($sformatf("b2b%0d_data", j), exp_word(8'(12 * (j / 12)), 12));
      end
    end
    apply(1'b0, 8'h00, 1'b0, 1'b1);
    step();
    chk("b2b_wc", 32'(word_count), 32'd5);
    chk("b2b_idle_mvld", 32'(m_axis_tvalid), 32'd0);

    // Backpressure: word 1 held, word 2 parks in the accumulator.
    for (int j = 0; j < 24; j++) begin
      apply(1'b1, 8'h40 + 8'(j), (j == 11), 1'b0);
      step();
      chk($sformatf("bp%0d_srdy", j), 32'(s_axis_tready), 32'(j < 23));
      chk($sformatf("bp%0d_mvld", j), 32'(m_axis_tvalid), 32'(j >= 11));
      if (j >= 11) begin
        chk($sformatf("bp%0d_tlast", j), 32'(m_axis_tlast), 32'h800);
        chk_data($sformatf("bp%0d_data", j), exp_word(8'h40, 12));
      end
    end
    for (int j = 0; j < 2; j++) begin
      apply(1'b0, 8'h00, 1'b0, 1'b0);
      step();
      chk("bp_hold_srdy", 32'(s_axis_tready), 32'd0);
      chk("bp_hold_mvld", 32'(m_axis_tvalid), 32'd1);
      chk_data("bp_hold_data", exp_word(8'h40, 12));
      chk("bp_hold_wc", 32'(word_count), 32'd5);
    end
    apply(1'b0, 8'h00, 1'b0, 1'b1);
    step();
    chk("bp_w2_mvld", 32'(m_axis_tvalid), 32'd1);
    chk("bp_w2_srdy", 32'(s_axis_tready), 32'd1);
    chk("bp_w2_tlast", 32'(m_axis_tlast), 32'h000);
    chk_data("bp_w2_data", exp_word(8'h4C, 12));
    chk("bp_w2_wc", 32'(word_count), 32'd6);
    step();
    chk("bp_end_mvld", 32'(m_axis_tvalid), 32'd0);
    chk("bp_end_wc", 32'(word_count), 32'd7);

    // Reset mid-fill: partial word discarded, next word starts at lane 0.
    for (int j = 0; j < 7; j++) begin
      apply(1'b1, 8'h70 + 8'(j), 1'b0, 1'b1);
      step();
    end
    apply(1'b0, 8'h00, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    chk_reset_state("rstmid");
    step();
    chk_reset_state("rstmid_hold");
    rst = 1'b0;
    for (int j = 0; j < 12; j++) begin
      apply(1'b1, 8'h90 + 8'(j), (j == 11), 1'b1);
      step();
    end
    chk("rst_w_mvld", 32'(m_axis_tvalid), 32'd1);
    chk("rst_w_tlast", 32'(m_axis_tlast), 32'h800);
    chk_data("rst_w_data", exp_word(8'h90, 12));
    apply(1'b0, 8'h00, 1'b0, 1'b1);
    step();
    chk("rst_w_wc", 32'(word_count), 32'd1);

    // Wrap: single-beat packets, one output handshake per cycle.
    rst = 1'b1;
    step();
    rst = 1'b0;
    apply(1'b1, 8'h00, 1'b1, 1'b1);
    step();
    chk("wrap_first_mvld", 32'(m_axis_tvalid), 32'd1);
    chk("wrap_first_tlast", 32'(m_axis_tlast), 32'h001);
    chk_data("wrap_first_data", exp_word(8'h00, 1));
    for (int i = 1; i < 65535; i++) begin
      apply(1'b1, 8'(i), 1'b1, 1'b1);
      step();
    end
    chk("wrap_stream_srdy", 32'(s_axis_tready), 32'd1);
    chk("wrap_stream_mvld", 32'(m_axis_tvalid), 32'd1);
    chk_data("wrap_stream_data", exp_word(8'hFE, 1));
    apply(1'b0, 8'h00, 1'b0, 1'b1);
    step();
    chk("wrap_ffff", 32'(word_count), 32'h0000FFFF);
    apply(1'b1, 8'h5A, 1'b1, 1'b1);
    step();
    chk("wrap_last_tlast", 32'(m_axis_tlast), 32'h001);
    apply(1'b0, 8'h00, 1'b0, 1'b1);
    step();
    chk("wrap_zero", 32'(word_count), 32'h00000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/in128_out1536.md
Name: in128_out1536

Overview:
- Upsizing AXI-Stream width converter: packs 128-bit beats into 1536-bit words (12 lanes).
- Carries per-lane tlast into a 12-bit tlast vector.
- Feeds the 1536-bit inputs of the inter-switch (the 12-bit-tlast inputs a/b).
- Mirror of in1536_out128: lane 0 occupies the LSBs, so in128_out1536 followed by in1536_out128 reproduces the original beat order.

Parameters:
- IN_WIDTH, 128, width of one input beat / one output lane.
- RATIO, 12, lanes per output word; output width is IN_WIDTH*RATIO = 1536.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- s_axis_tdata  input  128  input beat.
- s_axis_tvalid  input  1  input beat valid.
- s_axis_tready  output  1  input ready (registered).
- s_axis_tlast  input  1  last beat of packet.
- m_axis_tdata  output  1536  packed word; lane k = bits [128k+127:128k].
- m_axis_tvalid  output  1  output word valid.
- m_axis_tready  input  1  downstream ready.
- m_axis_tlast  output  12  bit k set if lane k carried s_axis_tlast.
- word_count  output  16  number of output handshakes since reset; wraps 0xFFFF->0.

Behaviour:
- Reset values (async, rst=1): s_axis_tready=1, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, word_count=0. Internal state also resets: lane_cnt=0, acc=0, acc_tlast=0, pending=0.
- An input handshake is s_axis_tvalid & s_axis_tready. On each handshake:
  - write the beat into acc lane lane_cnt;
  - set acc_tlast[lane_cnt] = s_axis_tlast.
- Completing beat: a handshake with lane_cnt==RATIO-1 or s_axis_tlast==1.
  - On a non-completing handshake: lane_cnt increments.
- Output slot free: ~m_axis_tvalid | m_axis_tready (current cycle).
- Completing beat with slot free:
  - next edge loads m_axis_tdata/m_axis_tlast with acc merged with the current beat, and sets m_axis_tvalid=1;
  - acc, acc_tlast and lane_cnt clear to 0.
  - Latency: completing beat to m_axis_tvalid is 1 cycle.
- Completing beat with slot busy:
  - merged word stays in acc; pending=1; s_axis_tready=0 from the next cycle.
  - On the first cycle the slot is free, acc moves to the output, acc/lane_cnt clear, pending=0, and s_axis_tready returns to 1 on the next edge.
- s_axis_tready = ~pending, registered. It never depends combinationally on s_axis_tvalid or s_axis_tlast.
- Early tlast (lane_cnt<11): unwritten lanes are zero because acc is cleared after every transfer. Exactly one m_axis_tlast bit is set, at the last written lane.
- m_axis_tvalid clears on an output handshake unless a new word loads the same cycle. A simultaneous output handshake and new load is legal and keeps tvalid high (full throughput).
- Throughput: with m_axis_tready held 1, one input beat per cycle sustained and no bubbles; one output word per 12 input beats.
- AXI rule: m_axis_tdata/m_axis_tlast hold stable while m_axis_tvalid & ~m_axis_tready.
- word_count increments on each m_axis_tvalid & m_axis_tready.
- s_axis_tvalid with s_axis_tready=0 is ignored. Data must be held by upstream per AXI.
- Reset mid-fill or mid-pending: partial word and pending word are discarded; the first beat after reset is lane 0.

Test Plan:
- Full word: 12 beats, beat k = {16{k[7:0]}}, tlast on beat 11, m_axis_tready=1. Expect one word, lane k = beat k, m_axis_tlast=12'h800, tvalid 1 cycle after beat 11, word_count=1.
- Early tlast: 5 beats 0xA0..0xA4 with tlast on beat 4. Expect lanes 0-4 = data, lanes 5-11 = 0, m_axis_tlast=12'h010.
- Back-to-back: 36 continuous beats, tready=1. Expect s_axis_tready never low and 3 words on cycles 12, 24, 36. Words carry lanes in order; word_count=3.
- Backpressure: m_axis_tready=0 after word 1, 24 beats offered. Expect word 1 held stable, word 2 pending, s_axis_tready=0 from the cycle after beat 23. Raise tready: word 1 then word 2 emitted, s_axis_tready back to 1.
- Reset mid-fill: 7 beats, assert rst 1 cycle, then 12 new beats. Expect all outputs zero during reset and only the new 12 beats in the next word.
- word_count wrap: force 65536 output handshakes (or preload in a fast sim). Expect 0xFFFF->0x0000.
